program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- Program-counter register for the single-cycle (monocycle) RISC-V-style datapath.
- Each clock it loads the next-PC value computed by the datapath (PC+4, branch or jump target) and presents it as the current fetch address to instruction memory.
- It also provides the sequential successor address and an alignment flag, so the surrounding logic does not duplicate that arithmetic.

Parameters:
- WIDTH, 32, bit width of all address ports.
- RESET_VALUE, 32'h0000_0000, value loaded into pc_out while reset is asserted; must be 4-byte aligned.
- INCREMENT, 4, byte stride added to form pc_seq.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted, 1 = run).
- pc_in  input  WIDTH  next-PC value from the datapath next-PC mux.
- pc_out  output  WIDTH  current PC, registered; fetch address.
- pc_seq  output  WIDTH  pc_out + INCREMENT, combinational from pc_out.
- pc_misaligned  output  1  high when pc_out[1:0] != 2'b00; combinational from pc_out.

Behaviour:
- Reset entry: reset falling to 0 immediately forces pc_out = RESET_VALUE, with no clock edge required.
  - While reset = 0, pc_out holds RESET_VALUE regardless of clk and pc_in.
  - Consequently pc_seq = RESET_VALUE + INCREMENT and pc_misaligned = 0.
- Reset release:
  - Release (reset 0->1) is not synchronized inside the block; the system provides a release clean with respect to clk.
  - The first rising edge with reset = 1 loads pc_in.
- Normal operation: on each rising clk edge with reset = 1, pc_out <= pc_in.
  - Latency is 1 cycle; there is no enable or stall.
  - pc_in is loaded verbatim; there is no masking or alignment correction.
- pc_seq: unsigned modulo-2^WIDTH addition with no carry-out.
  - Wrap case: pc_out = 32'hFFFF_FFFC gives pc_seq = 32'h0000_0000.
- pc_misaligned: pure decode of pc_out[1:0]; it never alters pc_out. Trapping is handled elsewhere.
- Reset asserted mid-operation: pc_out returns to RESET_VALUE at the moment of assertion. Any value in flight on pc_in is discarded.
- Reset coinciding with a clock edge: reset dominates and pc_out = RESET_VALUE.
- pc_in changing between edges: pc_out is unaffected until the next rising edge.
- X/undriven pc_in outside reset propagates to pc_out; the bench drives pc_in at all times.
- No internal state besides the WIDTH-bit PC register.

Test Plan:
- Hold reset = 0 with pc_in = 32'h0000_0000 and clk toggling -> pc_out = 32'h0000_0000, pc_seq = 32'h0000_0004, pc_misaligned = 0.
- Release reset = 1, drive pc_in = 32'h0000_0004, wait one rising edge -> pc_out = 32'h0000_0004, pc_seq = 32'h0000_0008.
- With pc_out = 32'h0000_0004, drive reset = 0 midway between edges -> pc_out = 32'h0000_0000 immediately, before the next edge; it stays there while reset = 0 even though pc_in = 32'h0000_0004.
- Release reset = 1, drive pc_in = 32'h0000_0008, one edge -> pc_out = 32'h0000_0008. Then change pc_in to 32'h0000_0020 between edges -> pc_out stays 32'h0000_0008 until the next edge, then becomes 32'h0000_0020.
- Load pc_in = 32'hFFFF_FFFC -> pc_out = 32'hFFFF_FFFC, pc_seq = 32'h0000_0000 (wrap).
- Load pc_in = 32'h0000_0006 -> pc_out = 32'h0000_0006, pc_misaligned = 1. Then load 32'h0000_000C -> pc_misaligned = 0.

Source files
------------

// File: rtl/program_counter.sv
// Program-counter register for the single-cycle datapath.
// Holds the current fetch address, loads the next-PC value every clock,
// and exposes the sequential successor address plus an alignment flag
// so the surrounding datapath does not repeat that arithmetic.
module program_counter #(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = 32'h0000_0000,
  parameter int unsigned       INCREMENT   = 4
) (
  input  logic             clk,
  input  logic             reset,         // asynchronous, active-low
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_seq,
  output logic             pc_misaligned
);

  // Stride sized to the address width so the sum wraps modulo 2^WIDTH.
  localparam logic [WIDTH-1:0] STRIDE = WIDTH'(INCREMENT);

  logic [WIDTH-1:0] pc_reg;

  // PC register: reset forces RESET_VALUE immediately, otherwise load pc_in each edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg <= RESET_VALUE;
    end else begin
      pc_reg <= pc_in;
    end
  end

  // Derived outputs: successor address (carry-out dropped) and low-bit alignment decode.
  always_comb begin
    pc_out        = pc_reg;
    pc_seq        = pc_reg + STRIDE;
    pc_misaligned = |pc_reg[1:0];
  end

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter.
module tb_program_counter;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
  logic [31:0] pc_seq;
  logic        pc_misaligned;

  int checks   = 0;
  int failures = 0;

  program_counter #(
    .WIDTH      (32),
    .RESET_VALUE(32'h0000_0000),
    .INCREMENT  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_in        (pc_in),
    .pc_out       (pc_out),
    .pc_seq       (pc_seq),
    .pc_misaligned(pc_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0;
    pc_in = 32'h0000_0000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pc_out !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_pc_out actual=%h expected=%h", pc_out, 32'h0000_0000);
    end
    checks++;
    if (pc_seq !== 32'h0000_0004) begin
      failures++;
      $display("FAIL reset_pc_seq actual=%h expected=%h", pc_seq, 32'h0000_0004);
    end
    checks++;
    if (pc_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL reset_misaligned actual=%b expected=%b", pc_misaligned, 1'b0);
    end
    // pc_in is ignored while reset is held
    @(negedge clk);
    pc_in = 32'h0000_0040;
    @(posedge clk);
    #1;
    checks++;
    if (pc_out !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_ignores_pc_in actual=%h expected=%h", pc_out, 32'h0000_0000);
    end
    $display("reset: pc_out=%h pc_seq=%h mis=%b", pc_out, pc_seq, pc_misaligned);
  endtask

  task automatic test_release();
    @(negedge clk);
    reset = 1'b1;
    pc_in = 32'h0000_0004;
    #1;
    checks++;
    if (pc_out !== 32'h0000_0000) begin
      failures++;
      $display("FAIL release_before_edge actual=%h expected=%h", pc_out, 32'h0000_0000);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pc_out !== 32'h0000_0004) begin
      failures++;
      $display("FAIL release_pc_out actual=%h expected=%h", pc_out, 32'h0000_0004);
    end
    checks++;
    if (pc_seq !== 32'h0000_0008) begin
      failures++;
      $display("FAIL release_pc_seq actual=%h expected=%h", pc_seq, 32'h0000_0008);
    end
    $display("release: pc_in=%h pc_out=%h pc_seq=%h", pc_in, pc_out, pc_seq);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (pc_out !== 32'h0000_0000) begin
      failures++;
      $display("FAIL async_reset_immediate actual=%h expected=%h", pc_out, 32'h0000_0000);
    end
    checks++;
    if (pc_seq !== 32'h0000_0004) begin
      failures++;
      $display("FAIL async_reset_pc_seq actual=%h expected=%h", pc_seq, 32'h0000_0004);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc_out !== 32'h0000_0000) begin
      failures++;
      $display("FAIL async_reset_hold actual=%h expected=%h", pc_out, 32'h0000_0000);
    end
    $display("async_reset: pc_in=%h pc_out=%h", pc_in, pc_out);
  endtask

  task automatic test_hold_between_edges();
    @(negedge clk);
    reset = 1'b1;
    pc_in = 32'h0000_0008;
    @(posedge clk);
    #1;
    checks++;
    if (pc_out !== 32'h0000_0008) begin
      failures++;
      $display("FAIL hold_first_load actual=%h expected=%h", pc_out, 32'h0000_0008);
    end
    @(negedge clk);
    pc_in = 32'h0000_0020;
    #1;
    checks++;
    if (pc_out !== 32'h0000_0008) begin
      failures++;
      $display("FAIL hold_between_edges actual=%h expected=%h", pc_out, 32'h0000_0008);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pc_out !== 32'h0000_0020) begin
      failures++;
      $display("FAIL hold_next_edge actual=%h expected=%h", pc_out, 32'h0000_0020);
    end
    checks++;
    if (pc_seq !== 32'h0000_0024) begin
      failures++;
      $display("FAIL hold_pc_seq actual=%h expected=%h", pc_seq, 32'h0000_0024);
    end
    $display("hold: pc_out=%h pc_seq=%h", pc_out, pc_seq);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    pc_in = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    checks++;
    if (pc_out !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_pc_out actual=%h expected=%h", pc_out, 32'hFFFF_FFFC);
    end
    checks++;
    if (pc_seq !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap_pc_seq actual=%h expected=%h", pc_seq, 32'h0000_0000);
    end
    checks++;
    if (pc_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL wrap_misaligned actual=%b expected=%b", pc_misaligned, 1'b0);
    end
    $display("wrap: pc_out=%h pc_seq=%h", pc_out, pc_seq);
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    pc_in = 32'h0000_0006;
    @(posedge clk);
    #1;
    checks++;
    if (pc_out !== 32'h0000_0006) begin
      failures++;
      $display("FAIL mis_pc_out actual=%h expected=%h", pc_out, 32'h0000_0006);
    end
    checks++;
    if (pc_misaligned !== 1'b1) begin
      failures++;
      $display("FAIL mis_flag_set actual=%b expected=%b", pc_misaligned, 1'b1);
    end
    checks++;
    if (pc_seq !== 32'h0000_000A) begin
      failures++;
      $display("FAIL mis_pc_seq actual=%h expected=%h", pc_seq, 32'h0000_000A);
    end
    $display("misaligned: pc_out=%h mis=%b", pc_out, pc_misaligned);
    @(negedge clk);
    pc_in = 32'h0000_000C;
    @(posedge clk);
    #1;
    checks++;
    if (pc_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL mis_flag_clear actual=%b expected=%b", pc_misaligned, 1'b0);
    end
    checks++;
    if (pc_out !== 32'h0000_000C) begin
      failures++;
      $display("FAIL mis_clear_pc_out actual=%h expected=%h", pc_out, 32'h0000_000C);
    end
    $display("aligned: pc_out=%h mis=%b", pc_out, pc_misaligned);
  endtask

  task automatic test_back_to_back();
    logic [31:0] vec_in  [5];
    logic [31:0] vec_seq [5];
    logic        vec_mis [5];
    vec_in[0] = 32'h0000_0100; vec_seq[0] = 32'h0000_0104; vec_mis[0] = 1'b0;
    vec_in[1] = 32'h0000_0203; vec_seq[1] = 32'h0000_0207; vec_mis[1] = 1'b1;
    vec_in[2] = 32'h7FFF_FFFE; vec_seq[2] = 32'h8000_0002; vec_mis[2] = 1'b1;
    vec_in[3] = 32'hFFFF_FFFF; vec_seq[3] = 32'h0000_0003; vec_mis[3] = 1'b1;
    vec_in[4] = 32'h0000_1000; vec_seq[4] = 32'h0000_1004; vec_mis[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pc_in = vec_in[i];
      @(posedge clk);
      #1;
      checks++;
      if (pc_out !== vec_in[i]) begin
        failures++;
        $display("FAIL b2b_pc_out[%0d] actual=%h expected=%h", i, pc_out, vec_in[i]);
      end
      checks++;
      if (pc_seq !== vec_seq[i]) begin
        failures++;
        $display("FAIL b2b_pc_seq[%0d] actual=%h expected=%h", i, pc_seq, vec_seq[i]);
      end
      checks++;
      if (pc_misaligned !== vec_mis[i]) begin
        failures++;
        $display("FAIL b2b_mis[%0d] actual=%b expected=%b", i, pc_misaligned, vec_mis[i]);
      end
      $display("b2b[%0d]: pc_in=%h pc_out=%h pc_seq=%h mis=%b", i, pc_in, pc_out, pc_seq,
               pc_misaligned);
    end
  endtask

  initial begin
    reset = 1'b0;
    pc_in = 32'h0000_0000;
    test_reset();
    test_release();
    test_async_reset();
    test_hold_between_edges();
    test_wrap();
    test_misaligned();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
